// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture for the single-cycle CPU debug ports.
// Captures samples of {pc, instr, pc_next, alu_result, flags} until a trigger is seen.
// It then records POST_TRIG further samples, freezes, and replays the entries oldest-first.
// Ports:
//   clk, rst (sync, active-low), arm (restart capture)
//   cap_valid plus the sample fields: sample input
//   trig_mode, trig_pc, trig_force: trigger selection
//   busy, triggered, done, count: capture status
//   rd_en to rd_valid with the rd_* fields: one entry per accepted request, next cycle
module cpu_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     cap_valid,
  input  logic [1:0]               trig_mode,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     trig_force,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        instr,
  input  logic [DATA_W-1:0]        pc_next,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic [5:0]               flags,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_pc_next,
  output logic [DATA_W-1:0]        rd_alu_result,
  output logic [5:0]               rd_flags,
  output logic                     rd_trig,
  output logic                     rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 * DATA_W + 7;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_e;

  state_e            state_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, remaining_q, post_cnt_q;
  logic              triggered_q, busy_q, done_q;
  logic              rd_valid_q, rd_trig_q, rd_last_q;
  logic [DATA_W-1:0] rd_pc_q, rd_instr_q, rd_pc_next_q, rd_alu_result_q;
  logic [5:0]        rd_flags_q;

  logic [EW-1:0]     mem_q [DEPTH];

  logic              capturing, wr_en, trig_hit, trig_bit, rd_fire;
  logic [AW-1:0]     wr_ptr_d, oldest_d;
  logic [CW-1:0]     count_d;
  logic [EW-1:0]     rd_ent;

  // Flag bit order: {aluZero, regWrite, branch, condZero, aluSrc, memWrite}.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      2'd0:    trig_hit = (pc == trig_pc);
      2'd1:    trig_hit = flags[0];
      2'd2:    trig_hit = flags[3] & flags[5];
      default: trig_hit = trig_force;
    endcase
  end

  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
  // arm in the same cycle discards the sample; reset blocks all writes.
  assign wr_en     = rst && !arm && cap_valid && capturing;
  // Only the sample that fires the trigger in ARMED carries the trig bit.
  assign trig_bit  = (state_q == S_ARMED) && trig_hit;
  assign rd_fire   = (state_q == S_DONE) && rd_en && (remaining_q != '0);

  assign wr_ptr_d  = wr_ptr_q + AW'(1);
  assign count_d   = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
  // Oldest entry after this write. When the buffer is full the low bits of
  // count are zero, so this lands on the next write slot, which holds the oldest entry.
  assign oldest_d  = wr_ptr_d - count_d[AW-1:0];

  assign rd_ent    = mem_q[rd_ptr_q];

  // Entry storage is not reset because contents are only read after a full capture.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {pc, instr, pc_next, alu_result, flags, trig_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      remaining_q     <= '0;
      post_cnt_q      <= '0;
      triggered_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_trig_q       <= 1'b0;
      rd_last_q       <= 1'b0;
      rd_pc_q         <= '0;
      rd_instr_q      <= '0;
      rd_pc_next_q    <= '0;
      rd_alu_result_q <= '0;
      rd_flags_q      <= '0;
    end else if (arm) begin
      // arm takes priority over any pending read or sample.
      state_q     <= S_ARMED;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        S_ARMED: begin
          if (cap_valid) begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (trig_hit) begin
              triggered_q <= 1'b1;
              if (POST_TRIG == 0) begin
                state_q     <= S_DONE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                rd_ptr_q    <= oldest_d;
                remaining_q <= count_d;
              end else begin
                state_q    <= S_POST;
                post_cnt_q <= CW'(POST_TRIG);
              end
            end
          end
        end
        S_POST: begin
          if (cap_valid) begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_q - CW'(1);
            if (post_cnt_q == CW'(1)) begin
              state_q     <= S_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              rd_ptr_q    <= oldest_d;
              remaining_q <= count_d;
            end
          end
        end
        S_DONE: begin
          if (rd_fire) begin
            rd_valid_q      <= 1'b1;
            rd_pc_q         <= rd_ent[4*DATA_W+6 -: DATA_W];
            rd_instr_q      <= rd_ent[3*DATA_W+6 -: DATA_W];
            rd_pc_next_q    <= rd_ent[2*DATA_W+6 -: DATA_W];
            rd_alu_result_q <= rd_ent[DATA_W+6 -: DATA_W];
            rd_flags_q      <= rd_ent[6:1];
            rd_trig_q       <= rd_ent[0];
            rd_last_q       <= (remaining_q == CW'(1));
            rd_ptr_q        <= rd_ptr_q + AW'(1);
            remaining_q     <= remaining_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = busy_q;
  assign triggered     = triggered_q;
  assign done          = done_q;
  assign count         = count_q;
  assign rd_valid      = rd_valid_q;
  assign rd_pc         = rd_pc_q;
  assign rd_instr      = rd_instr_q;
  assign rd_pc_next    = rd_pc_next_q;
  assign rd_alu_result = rd_alu_result_q;
  assign rd_flags      = rd_flags_q;
  assign rd_trig       = rd_trig_q;
  assign rd_last       = rd_last_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: drives cpu_trace_buffer (DEPTH=8, POST_TRIG=3).
// It uses directed scenarios and random traffic, and compares every cycle against a queue-based model.
module tb_cpu_trace_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int POST  = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, arm, cap_valid, trig_force, rd_en;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_pc, pc, instr, pc_next, alu_result;
  logic [5:0]    flags;
  logic          busy, triggered, done, rd_valid, rd_trig, rd_last;
  logic [CW-1:0] count;
  logic [DW-1:0] rd_pc, rd_instr, rd_pc_next, rd_alu_result;
  logic [5:0]    rd_flags;

  cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(POST)) dut (
    .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid),
    .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_force(trig_force),
    .pc(pc), .instr(instr), .pc_next(pc_next), .alu_result(alu_result), .flags(flags),
    .busy(busy), .triggered(triggered), .done(done), .count(count),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_pc_next(rd_pc_next), .rd_alu_result(rd_alu_result), .rd_flags(rd_flags),
    .rd_trig(rd_trig), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  // Reference model: captured samples live in a queue capped at DEPTH.
  typedef struct {
    logic [DW-1:0] pc, instr, pcn, alu;
    logic [5:0]    flags;
    logic          trig;
  } ent_t;

  ent_t          q[$];
  int            m_st = 0;   // 0 idle, 1 waiting for trigger, 2 post-trigger, 3 frozen
  int            m_post = 0;
  int            m_rd = 0;
  bit            m_trig = 0;
  bit            e_rv = 0;
  bit            e_last = 0;
  ent_t          e_ent;
  logic [DW-1:0] e_hold_pc = '0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit();
    case (trig_mode)
      2'd0:    return pc == trig_pc;
      2'd1:    return flags[0];
      2'd2:    return flags[5] & flags[3];
      default: return trig_force;
    endcase
  endfunction

  task automatic m_push(input bit t);
    ent_t e;
    e.pc = pc; e.instr = instr; e.pcn = pc_next; e.alu = alu_result;
    e.flags = flags; e.trig = t;
    q.push_back(e);
    if (q.size() > DEPTH) void'(q.pop_front());
  endtask

  // Applies the current inputs as one clock edge to the model.
  task automatic model_edge();
    bit h;
    e_rv = 0;
    if (!rst) begin
      m_st = 0; q.delete(); m_trig = 0; m_rd = 0; m_post = 0;
      e_hold_pc = '0;
    end else if (arm) begin
      m_st = 1; q.delete(); m_trig = 0; m_rd = 0;
    end else begin
      case (m_st)
        1: if (cap_valid) begin
          h = m_hit();
          m_push(h);
          if (h) begin
            m_trig = 1;
            if (POST == 0) m_st = 3;
            else begin m_post = POST; m_st = 2; end
          end
        end
        2: if (cap_valid) begin
          m_push(0);
          m_post--;
          if (m_post == 0) m_st = 3;
        end
        3: if (rd_en && m_rd < q.size()) begin
          e_rv = 1;
          e_ent = q[m_rd];
          e_last = (m_rd == q.size() - 1);
          e_hold_pc = e_ent.pc;
          m_rd++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("busy", busy, (m_st == 1 || m_st == 2));
    chk("done", done, (m_st == 3));
    chk("triggered", triggered, m_trig);
    chk("count", count, q.size());
    chk("rd_valid", rd_valid, e_rv);
    chk("rd_pc", rd_pc, e_hold_pc);
    if (e_rv) begin
      chk("rd_instr", rd_instr, e_ent.instr);
      chk("rd_pc_next", rd_pc_next, e_ent.pcn);
      chk("rd_alu_result", rd_alu_result, e_ent.alu);
      chk("rd_flags", rd_flags, e_ent.flags);
      chk("rd_trig", rd_trig, e_ent.trig);
      chk("rd_last", rd_last, e_last);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic quiet();
    rst = 1; arm = 0; cap_valid = 0; trig_force = 0; rd_en = 0;
  endtask

  task automatic rand_fields();
    instr = $urandom; pc_next = $urandom; alu_result = $urandom;
  endtask

  task automatic do_arm();
    quiet(); arm = 1; tick(); arm = 0;
  endtask

  // Sequential-pc capture using trigger mode 0, followed by a full readout with rd_en held high.
  task automatic pc_run(input logic [DW-1:0] tpc, input int exp_cnt, input logic [DW-1:0] first);
    int k;
    do_arm();
    trig_mode = 2'd0; trig_pc = tpc; cap_valid = 1; flags = 6'h00; k = 0;
    while (!done && k < 40) begin
      pc = DW'(k * 4); rand_fields(); tick(); k++;
    end
    cap_valid = 0;
    chk("run_done", done, 1);
    chk("run_count", count, exp_cnt);
    rd_en = 1;
    for (int i = 0; i < exp_cnt; i++) begin
      tick();
      chk("run_rd_pc", rd_pc, first + DW'(4 * i));
      chk("run_rd_trig", rd_trig, ((first + DW'(4 * i)) == tpc));
      chk("run_rd_last", rd_last, (i == exp_cnt - 1));
    end
    tick();
    chk("run_rd_after_last", rd_valid, 0);
    rd_en = 0;
  endtask

  // Trigger on the 3rd valid sample while cap_valid alternates.
  task automatic gap_run(input logic [1:0] mode);
    int v, j;
    do_arm();
    trig_mode = mode; trig_pc = 32'hFFFF_FFF0; v = 0; j = 0;
    while (!done && j < 60) begin
      cap_valid = (j % 2 == 0);
      pc = DW'(j * 4); rand_fields();
      flags = 6'($urandom) & 6'h3E;
      trig_force = 0;
      if (cap_valid && v == 2) begin
        if (mode == 2'd1) flags[0] = 1'b1;
        else trig_force = 1'b1;
      end
      tick();
      if (cap_valid) v++;
      j++;
    end
    quiet();
    chk("gap_done", done, 1);
    chk("gap_valid_samples", v, 6);
    chk("gap_count", count, 6);
    for (int i = 0; i < 14; i++) begin
      rd_en = (i % 2 == 0);
      tick();
    end
    rd_en = 0;
  endtask

  initial begin
    quiet();
    trig_mode = 0; trig_pc = 0; pc = 0; flags = 0;
    instr = 0; pc_next = 0; alu_result = 0;

    // Reset holds off arm and read.
    rst = 0; arm = 1; rd_en = 1;
    tick(); tick();
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_trig", rd_trig, 0);
    quiet();

    pc_run(32'h18, 8, 32'h08);   // wrap with mid-buffer trigger
    pc_run(32'h00, 4, 32'h00);   // early trigger
    gap_run(2'd1);
    gap_run(2'd3);

    // Reset during POST.
    do_arm();
    trig_mode = 2'd3; trig_force = 1; cap_valid = 1; pc = 32'h40; rand_fields(); tick();
    trig_force = 0; pc = 32'h44; tick();
    chk("post_busy", busy, 1);
    cap_valid = 0; rst = 0; tick(); rst = 1;
    chk("rst_post_triggered", triggered, 0);
    chk("rst_post_count", count, 0);
    rd_en = 1; tick(); tick();
    chk("rst_post_no_read", rd_valid, 0);
    quiet();

    // arm while reading out.
    pc_run(32'h18, 8, 32'h08);
    pc_run(32'h18, 8, 32'h08);
    do_arm();
    trig_mode = 2'd0; trig_pc = 32'h18; cap_valid = 1;
    for (int k = 0; k < 40 && !done; k++) begin pc = DW'(k * 4); rand_fields(); tick(); end
    cap_valid = 0; rd_en = 1; tick(); tick();
    chk("arm_rd2_pc", rd_pc, 32'h0C);
    arm = 1; tick(); arm = 0;
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
    chk("arm_count", count, 0);
    chk("arm_no_read", rd_valid, 0);
    tick();
    chk("arm_no_read2", rd_valid, 0);
    quiet();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 249) != 0);
      arm        = ($urandom_range(0, 49) == 0);
      cap_valid  = ($urandom_range(0, 9) < 7);
      trig_mode  = 2'($urandom);
      pc         = DW'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 19) == 0) trig_pc = DW'($urandom_range(0, 15) * 4);
      flags      = 6'($urandom);
      trig_force = ($urandom_range(0, 7) == 0);
      rd_en      = ($urandom_range(0, 1) == 1);
      rand_fields();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Parametrised hardware trace capture for the single-cycle CPU; the synthesizable successor to the $monitor-based CPU bench printout.
- Samples PC, instr, pcNext, aluResult and six control flags into a circular buffer.
- Freezes a configurable post-trigger window around a trigger event.
- Replays entries oldest-first through a read handshake.
- Sits beside CPU, fed from the same debug ports; readable by bench or debug logic.

Parameters:
- DATA_W, 32, width of pc/instr/pc_next/alu_result fields.
- DEPTH, 16, entries in the buffer; power of two, >= 2.
- POST_TRIG, 8, samples captured after the trigger sample; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- arm  in  1  pulse: clear buffer, start capture.
- cap_valid  in  1  current inputs form a sample this cycle.
- trig_mode  in  2  0 = pc==trig_pc, 1 = flags memWrite, 2 = flags branch & aluZero, 3 = trig_force.
- trig_pc  in  DATA_W  PC match value for mode 0.
- trig_force  in  1  manual trigger for mode 3.
- pc, instr, pc_next, alu_result  in  DATA_W each  sample fields.
- flags  in  6  {aluZero, regWrite, branch, condZero, aluSrc, memWrite}, MSB first.
- busy  out  1  state is ARMED or POST.
- triggered  out  1  trigger seen, held until arm/reset.
- done  out  1  state is DONE.
- count  out  $clog2(DEPTH)+1  valid entries stored, saturates at DEPTH.
- rd_en  in  1  read request.
- rd_valid  out  1  read data valid, one-cycle pulse per accepted rd_en.
- rd_pc, rd_instr, rd_pc_next, rd_alu_result  out  DATA_W  read fields.
- rd_flags  out  6  read flags.
- rd_trig  out  1  this entry is the trigger sample.
- rd_last  out  1  this entry is the final stored entry.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; wr_ptr, rd_ptr, count, post_cnt = 0. All outputs 0. Buffer contents don't-care. Reset overrides every other input in any state, including mid-POST and mid-readout.
- States: IDLE, ARMED, POST, DONE. arm in any state → ARMED, with wr_ptr = count = 0 and triggered = 0.
- ARMED: on each cap_valid cycle, write {fields, flags, trig bit} at wr_ptr. wr_ptr increments mod DEPTH (wraps); count increments, saturating at DEPTH. Trigger is evaluated only on cap_valid cycles. On trigger, the trigger sample is written with trig bit = 1 and triggered = 1. Then: if POST_TRIG == 0 → DONE, else post_cnt = POST_TRIG → POST.
- POST: each cap_valid writes an entry (trig bit 0) and decrements post_cnt. The write that brings post_cnt to 0 → DONE next cycle. Trigger conditions are ignored. cap_valid low: no write, no decrement.
- DONE: writes inhibited. On entry, rd_ptr = (wr_ptr - count) mod DEPTH (oldest entry) and remaining = count.
- Read handshake: rd_en in DONE with remaining > 0 → next cycle rd_valid = 1 with entry at rd_ptr; rd_ptr advances mod DEPTH; remaining decrements. rd_last = 1 when remaining was 1. rd_en may be held high for back-to-back reads at one entry per cycle. rd_en with remaining = 0 or outside DONE: ignored, rd_valid stays 0.
- rd_* fields hold their last value when rd_valid = 0.
- State after readout: stays DONE (done = 1) until arm or reset.
- Simultaneous events: arm and rd_en in the same cycle → arm wins, no read. arm and a cap_valid sample in the same cycle → sample not recorded.

Test Plan:
- Reset: hold rst=0 for 2 cycles with arm=1, rd_en=1 → busy=done=triggered=0, count=0, rd_valid=0.
- Wrap with mid-buffer trigger (DEPTH=8, POST_TRIG=3): arm; cap_valid=1, pc=0x00,0x04,…; trig_mode=0, trig_pc=0x18. Samples stop after pc=0x24 → done=1, count=8. Eight reads return pc 0x08..0x24 in order; rd_trig=1 on the 5th read (0x18); rd_last=1 on 0x24.
- Early trigger: trig_pc=0x00, same setup → count=4; reads pc 0x00,0x04,0x08,0x0C; rd_trig on the first read, rd_last on the fourth.
- Gaps and modes: trig_mode=1, memWrite=1 on the 3rd sample, cap_valid toggling 1/0 → only valid cycles are stored. POST completes after exactly 3 valid samples. Repeat with mode 3 and trig_force pulsed → identical structure.
- Reset mid-POST: rst=0 one cycle during POST → next cycle IDLE, count=0, triggered=0; subsequent rd_en gives no rd_valid.
- arm during readout: after 2 of 8 reads, assert arm → busy=1, done=0, count=0; a further rd_en gives no rd_valid.
